div_unit: RTL

Iterative radix-2 divider implementing RV32M DIV/DIVU/REM/REMU for the EX stage, sitting beside the ALU multiplier path. It accepts one request per instruction and asserts a combinational stall while it computes, in the same way the multiply path stalls the pipeline. It produces a single-cycle done pulse with the registered result, after which the pipeline advances.

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage iterative divider: operation select,
// FSM states and the default operand width.
package div_unit_pkg;

   localparam int DIV_WORD_WIDTH = 32;

   localparam logic [1:0] DIV_DIV  = 2'b00;
   localparam logic [1:0] DIV_DIVU = 2'b01;
   localparam logic [1:0] DIV_REM  = 2'b10;
   localparam logic [1:0] DIV_REMU = 2'b11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_CALC = 2'b01,
      DIV_DONE = 2'b10
   } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. Stalls the pipeline
// while iterating and pulses done for one cycle with the registered result.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WORD_WIDTH = DIV_WORD_WIDTH
)(
   input  logic                  CLK,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  kill,
   input  logic [1:0]            div_op,
   input  logic [WORD_WIDTH-1:0] op_a,
   input  logic [WORD_WIDTH-1:0] op_b,
   output logic [WORD_WIDTH-1:0] res,
   output logic                  done,
   output logic                  div_stall
);

   localparam int CNT_W = $clog2(WORD_WIDTH);
   localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(WORD_WIDTH - 1);
   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
   localparam logic [WORD_WIDTH-1:0] ONE       = WORD_WIDTH'(1);
   localparam logic [WORD_WIDTH-1:0] ZERO      = '0;
   localparam logic [WORD_WIDTH-1:0] ALL_ONES  = '1;
   localparam logic [WORD_WIDTH-1:0] MIN_NEG   = {1'b1, {(WORD_WIDTH-1){1'b0}}};

   div_state_e            state_r;
   logic [CNT_W-1:0]      count_r;
   logic [WORD_WIDTH-1:0] quo_r;
   logic [WORD_WIDTH-1:0] rem_r;
   logic [WORD_WIDTH-1:0] divisor_r;
   logic                  is_rem_r;
   logic                  neg_q_r;
   logic                  neg_r_r;
   logic [WORD_WIDTH-1:0] res_r;
   logic                  done_r;

   logic                  signed_op_s;
   logic                  a_neg_s;
   logic                  b_neg_s;
   logic [WORD_WIDTH-1:0] a_mag_s;
   logic [WORD_WIDTH-1:0] b_mag_s;
   logic                  div_zero_s;
   logic                  ovf_s;
   logic [WORD_WIDTH-1:0] special_res_s;
   logic [WORD_WIDTH:0]   rem_shift_s;
   logic [WORD_WIDTH+1:0] sub_s;
   logic                  borrow_s;
   logic [WORD_WIDTH-1:0] quo_next_s;
   logic [WORD_WIDTH-1:0] rem_next_s;
   logic [WORD_WIDTH-1:0] final_res_s;

   function automatic logic [WORD_WIDTH-1:0] negate(input logic [WORD_WIDTH-1:0] v);
      return (~v) + ONE;
   endfunction

   // Operand decode: magnitudes and the results that bypass iteration.
   always_comb begin
      signed_op_s   = ~div_op[0];
      a_neg_s       = signed_op_s & op_a[WORD_WIDTH-1];
      b_neg_s       = signed_op_s & op_b[WORD_WIDTH-1];
      a_mag_s       = a_neg_s ? negate(op_a) : op_a;
      b_mag_s       = b_neg_s ? negate(op_b) : op_b;
      div_zero_s    = (op_b == ZERO);
      ovf_s         = signed_op_s & (op_a == MIN_NEG) & (op_b == ALL_ONES);
      special_res_s = ZERO;
      if (div_zero_s) begin
         special_res_s = div_op[1] ? op_a : ALL_ONES;
      end else if (ovf_s) begin
         special_res_s = div_op[1] ? ZERO : MIN_NEG;
      end else begin
         special_res_s = ZERO;
      end
   end

   // One restoring step; the extra top bit of sub_s is the borrow.
   always_comb begin
      rem_shift_s = {rem_r, quo_r[WORD_WIDTH-1]};
      sub_s       = {1'b0, rem_shift_s} - {2'b00, divisor_r};
      borrow_s    = sub_s[WORD_WIDTH+1];
      quo_next_s  = {quo_r[WORD_WIDTH-2:0], ~borrow_s};
      rem_next_s  = borrow_s ? rem_shift_s[WORD_WIDTH-1:0] : sub_s[WORD_WIDTH-1:0];
      if (is_rem_r) begin
         final_res_s = neg_r_r ? negate(rem_next_s) : rem_next_s;
      end else begin
         final_res_s = neg_q_r ? negate(quo_next_s) : quo_next_s;
      end
   end

   // Stall request; held low during reset even if EX still presents a divide.
   always_comb begin
      div_stall = ~rst & (((state_r == DIV_IDLE) & start & ~kill) | (state_r == DIV_CALC));
   end

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_r   <= DIV_IDLE;
         count_r   <= '0;
         quo_r     <= ZERO;
         rem_r     <= ZERO;
         divisor_r <= ZERO;
         is_rem_r  <= 1'b0;
         neg_q_r   <= 1'b0;
         neg_r_r   <= 1'b0;
         res_r     <= ZERO;
         done_r    <= 1'b0;
      end else if (kill) begin
         state_r <= DIV_IDLE;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            DIV_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  is_rem_r <= div_op[1];
                  if (div_zero_s || ovf_s) begin
                     res_r   <= special_res_s;
                     done_r  <= 1'b1;
                     state_r <= DIV_DONE;
                  end else begin
                     quo_r     <= a_mag_s;
                     rem_r     <= ZERO;
                     divisor_r <= b_mag_s;
                     neg_q_r   <= a_neg_s ^ b_neg_s;
                     neg_r_r   <= a_neg_s;
                     count_r   <= '0;
                     state_r   <= DIV_CALC;
                  end
               end else begin
                  state_r <= DIV_IDLE;
               end
            end
            DIV_CALC: begin
               quo_r   <= quo_next_s;
               rem_r   <= rem_next_s;
               count_r <= count_r + CNT_ONE;
               if (count_r == LAST_STEP) begin
                  res_r   <= final_res_s;
                  done_r  <= 1'b1;
                  state_r <= DIV_DONE;
               end else begin
                  done_r  <= 1'b0;
                  state_r <= DIV_CALC;
               end
            end
            DIV_DONE: begin
               done_r  <= 1'b0;
               state_r <= DIV_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               state_r <= DIV_IDLE;
            end
         endcase
      end
   end

   assign res  = res_r;
   assign done = done_r;

endmodule
